// File: rtl/rv_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// rv_ctrl_fsm - multi-cycle RV32I control sequencer with instret counter and
//               memory-timeout trap.                                Rev 1.0
// ============================================================================
module rv_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op_code,
  input  logic [2:0]  f3,
  input  logic        f7,
  input  logic        flag,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        dmem_we,
  output logic        branch,
  output logic [1:0]  jump,
  output logic [1:0]  dato_s,
  output logic [1:0]  inm_src,
  output logic        reg_w,
  output logic        alu_s,
  output logic [2:0]  alu_op,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  cause
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BEQ, C_JAL, C_JALR
  } cls_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  cls_t        cls, dec_cls;
  logic [2:0]  alu_op_q, dec_alu_op;
  logic        dec_ok;
  logic [7:0]  wait_cnt, wait_nx;
  logic [1:0]  cause_nx;
  logic        commit;
  logic        flag_unused;

  // The branch decision itself is taken by the datapath from the zero flag.
  assign flag_unused = flag;
  assign commit      = (jump != 2'b00);

  always_comb begin
    dec_ok     = 1'b1;
    dec_cls    = C_R;
    dec_alu_op = 3'b000;
    case (op_code)
      7'b0110011: begin
        dec_cls = C_R;
        case (f3)
          3'b000:  dec_alu_op = f7 ? 3'b001 : 3'b000;
          3'b111:  begin dec_alu_op = 3'b010; dec_ok = !f7; end
          3'b110:  begin dec_alu_op = 3'b011; dec_ok = !f7; end
          3'b010:  begin dec_alu_op = 3'b101; dec_ok = !f7; end
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_cls = C_I;
        case (f3)
          3'b000:  dec_alu_op = 3'b000;
          3'b111:  dec_alu_op = 3'b010;
          3'b110:  dec_alu_op = 3'b011;
          3'b010:  dec_alu_op = 3'b101;
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0000011: begin dec_cls = C_LOAD;  dec_ok = (f3 == 3'b010); end
      7'b0100011: begin dec_cls = C_STORE; dec_ok = (f3 == 3'b010); end
      7'b1100011: begin
        dec_cls    = C_BEQ;
        dec_alu_op = 3'b100;
        dec_ok     = (f3 == 3'b000);
      end
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: begin dec_cls = C_JALR; dec_ok = (f3 == 3'b000); end
      default:    dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      cls      <= C_R;
      alu_op_q <= 3'b000;
      wait_cnt <= 8'd0;
      cause    <= 2'b00;
      instret  <= 32'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      cause    <= cause_nx;
      if (state == S_DECODE) begin
        cls      <= dec_cls;
        alu_op_q <= dec_alu_op;
      end
      if (commit) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = 8'd0;
    cause_nx = cause;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    branch   = 1'b0;
    jump     = 2'b00;
    dato_s   = 2'b00;
    inm_src  = 2'b00;
    reg_w    = 1'b0;
    alu_s    = 1'b0;
    alu_op   = 3'b000;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = S_TRAP;
          cause_nx = 2'b10;
        end else begin
          wait_nx = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          state_nx = S_EXEC;
        end else begin
          state_nx = S_TRAP;
          cause_nx = 2'b01;
        end
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (cls)
          C_R: begin
            reg_w = 1'b1; jump = 2'b01; alu_op = alu_op_q;
          end
          C_I: begin
            reg_w = 1'b1; jump = 2'b01; alu_op = alu_op_q; alu_s = 1'b1;
          end
          C_BEQ: begin
            branch = 1'b1; jump = 2'b01; alu_op = 3'b100; inm_src = 2'b10;
          end
          C_JAL: begin
            jump = 2'b10; inm_src = 2'b11; reg_w = 1'b1; dato_s = 2'b10;
          end
          C_JALR: begin
            jump = 2'b11; alu_s = 1'b1; reg_w = 1'b1; dato_s = 2'b10;
          end
          default: begin
            // Loads and stores only compute the address here.
            alu_s    = 1'b1;
            inm_src  = (cls == C_STORE) ? 2'b01 : 2'b00;
            state_nx = S_MEM;
          end
        endcase
      end
      S_MEM: begin
        alu_s    = 1'b1;
        inm_src  = (cls == C_STORE) ? 2'b01 : 2'b00;
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ack) begin
          if (cls == C_STORE) begin
            jump     = 2'b01;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = S_TRAP;
          cause_nx = 2'b11;
        end else begin
          wait_nx = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        reg_w    = 1'b1;
        dato_s   = 2'b01;
        jump     = 2'b01;
        state_nx = S_FETCH;
      end
      S_TRAP:  halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase
    // Reset silences every control output in the same cycle it is asserted.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      branch   = 1'b0;
      jump     = 2'b00;
      dato_s   = 2'b00;
      inm_src  = 2'b00;
      reg_w    = 1'b0;
      alu_s    = 1'b0;
      alu_op   = 3'b000;
      halted   = 1'b0;
    end
  end

endmodule
`default_nettype wire
